// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: FSM state
//   encodings, the hard-wired zero register index, the performance counter
//   width and a helper that turns a cycle count into a down-counter preload.
package hazard_ctrl_pkg;

  // FSM state encodings (2 bits)
  localparam logic [1:0] HZ_RUN   = 2'd0;
  localparam logic [1:0] HZ_STALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH = 2'd2;

  // Register $0 is hard-wired to zero, so a load targeting it never hazards
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Performance counter width
  localparam int CNT_W = 32;

  // Width of the remaining-cycles down-counter
  localparam int REM_W = 8;

  // The first hazard cycle is spent in RUN and the last one is the cycle in
  // which the counter reads zero, so a sequence of N cycles preloads N-2.
  function automatic logic [REM_W-1:0] cnt_load(input int cycles);
    return REM_W'(cycles - 2);
  endfunction

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// lu_detect
//   Combinational load-use comparator. Flags when the instruction in EX is a
//   load whose destination is read by the instruction in ID.
//   Ports:
//     ID_Rs, ID_Rt  in  5  source register selects of the ID instruction
//     ID_UsesRt     in  1  ID instruction actually reads rt
//     EX_MemR       in  1  EX instruction is a load
//     EX_Rt         in  5  load destination register
//     LoadUse       out 1  load-use hazard present
module lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       EX_MemR,
  input  logic [4:0] EX_Rt,
  output logic       LoadUse
);

  logic w_dst_live;
  logic w_rs_hit;
  logic w_rt_hit;

  // A load into $0 produces nothing to wait for
  assign w_dst_live = (EX_Rt != REG_ZERO);
  assign w_rs_hit   = (EX_Rt == ID_Rs);
  // rt is only a true dependency when the ID instruction reads it
  assign w_rt_hit   = ID_UsesRt & (EX_Rt == ID_Rt);

  assign LoadUse = EX_MemR & w_dst_live & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller at the control end of the ID/EX interface.
//   Detects load-use hazards and EX-stage redirects and drives the bubble,
//   PC / IF/ID write enables and the IF/ID flush, plus stall/flush counters.
//   Parameters:
//     LOAD_STALL   bubble cycles per load-use hazard (>=1)
//     FLUSH_CYCLES flush cycles per redirect (>=1)
//   Ports:
//     Clk, Rst        clock and synchronous active-high reset
//     ID_Rs, ID_Rt    register selects of the instruction in ID
//     ID_UsesRt       ID instruction reads rt
//     EX_MemR, EX_Rt  load flag / destination from the ID/EX register
//     BranchTaken     branch resolved taken in EX
//     Jump            jump in EX
//     Nop             bubble into ID/EX
//     PCWrite         PC update enable
//     IFIDWrite       IF/ID load enable
//     IFIDFlush       IF/ID clear
//     StallCnt        load-use stall cycles since reset
//     FlushCnt        redirect events since reset
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemR,
  input  logic [4:0]       EX_Rt,
  input  logic             BranchTaken,
  input  logic             Jump,
  output logic             Nop,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  logic [1:0]       r_state;
  logic [REM_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic [1:0]       w_state_next;
  logic [REM_W-1:0] w_cnt_next;
  logic             w_load_use;
  logic             w_redirect;

  lu_detect u_lu_detect (
    .ID_Rs     (ID_Rs),
    .ID_Rt     (ID_Rt),
    .ID_UsesRt (ID_UsesRt),
    .EX_MemR   (EX_MemR),
    .EX_Rt     (EX_Rt),
    .LoadUse   (w_load_use)
  );

  assign w_redirect = BranchTaken | Jump;

  // ---------------------------------------------------------------------------
  // Control outputs: combinational so the ID/EX register sees them on the
  // same edge that ends the hazard cycle. A redirect overrides everything
  // except reset, which holds the front end frozen with bubbles.
  // ---------------------------------------------------------------------------
  always_comb begin
    Nop       = 1'b0;
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    if (Rst) begin
      Nop       = 1'b1;
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
    end else if (w_redirect) begin
      Nop       = 1'b1;
      IFIDFlush = 1'b1;
    end else begin
      case (r_state)
        HZ_STALL: begin
          Nop       = 1'b1;
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
        end
        HZ_FLUSH: begin
          Nop       = 1'b1;
          IFIDFlush = 1'b1;
        end
        default: begin
          if (w_load_use) begin
            Nop       = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next state. The first cycle of every sequence is produced from RUN (or
  // from the interrupted state for a redirect), so only multi-cycle
  // sequences visit STALL/FLUSH.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = HZ_RUN;
    w_cnt_next   = '0;
    if (w_redirect) begin
      // Also restarts a FLUSH in progress and aborts a STALL
      if (FLUSH_CYCLES > 1) begin
        w_state_next = HZ_FLUSH;
        w_cnt_next   = cnt_load(FLUSH_CYCLES);
      end
    end else begin
      case (r_state)
        HZ_STALL, HZ_FLUSH: begin
          if (r_cnt != '0) begin
            w_state_next = r_state;
            w_cnt_next   = r_cnt - 1'b1;
          end
        end
        default: begin
          if (w_load_use && (LOAD_STALL > 1)) begin
            w_state_next = HZ_STALL;
            w_cnt_next   = cnt_load(LOAD_STALL);
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= HZ_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters; free-running with natural wrap.
  // A stall cycle is any non-reset cycle in which IF/ID is held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!IFIDWrite) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Two instances share the stimulus:
//   dut_a with default parameters (1/1) and dut_b with LOAD_STALL=3,
//   FLUSH_CYCLES=2. Control outputs are compared as {Nop,PCWrite,IFIDWrite,IFIDFlush}.
module tb_hazard_ctrl;

  localparam logic [3:0] CTL_NORM  = 4'b0110;
  localparam logic [3:0] CTL_STALL = 4'b1000;
  localparam logic [3:0] CTL_FLUSH = 4'b1111;
  localparam logic [3:0] CTL_RST   = 4'b1001;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, EX_MemR, BranchTaken, Jump;

  logic        a_nop, a_pcw, a_ifw, a_iff;
  logic        b_nop, b_pcw, b_ifw, b_iff;
  logic [31:0] a_stall, a_flush, b_stall, b_flush;
  logic [3:0]  a_ctl, b_ctl;

  int n_cmp = 0;
  int n_bad = 0;

  assign a_ctl = {a_nop, a_pcw, a_ifw, a_iff};
  assign b_ctl = {b_nop, b_pcw, b_ifw, b_iff};

  always #5 Clk = ~Clk;

  hazard_ctrl dut_a (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemR(EX_MemR), .EX_Rt(EX_Rt), .BranchTaken(BranchTaken), .Jump(Jump),
    .Nop(a_nop), .PCWrite(a_pcw), .IFIDWrite(a_ifw), .IFIDFlush(a_iff),
    .StallCnt(a_stall), .FlushCnt(a_flush)
  );

  hazard_ctrl #(.LOAD_STALL(3), .FLUSH_CYCLES(2)) dut_b (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemR(EX_MemR), .EX_Rt(EX_Rt), .BranchTaken(BranchTaken), .Jump(Jump),
    .Nop(b_nop), .PCWrite(b_pcw), .IFIDWrite(b_ifw), .IFIDFlush(b_iff),
    .StallCnt(b_stall), .FlushCnt(b_flush)
  );

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd1; ID_Rt = 5'd2; ID_UsesRt = 1'b0;
    EX_MemR = 1'b0; EX_Rt = 5'd0; BranchTaken = 1'b0; Jump = 1'b0;
  endtask

  task automatic set_load_use();
    EX_MemR = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1;
    idle_inputs();
    step();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1;
    idle_inputs();
    #1;
    n_cmp++;
    if (a_ctl !== CTL_RST) begin n_bad++; $display("FAIL rst_ctl: got %b required %b", a_ctl, CTL_RST); end
    step();
    n_cmp++;
    if (a_stall !== 32'd0 || a_flush !== 32'd0) begin
      n_bad++; $display("FAIL rst_cnt: got %0d/%0d required 0/0", a_stall, a_flush);
    end
    Rst = 1'b0;
    #1;
    n_cmp++;
    if (a_ctl !== CTL_NORM) begin n_bad++; $display("FAIL rst_run: got %b required %b", a_ctl, CTL_NORM); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    #1;
    n_cmp++;
    if (a_ctl !== CTL_STALL) begin n_bad++; $display("FAIL lu_stall: got %b required %b", a_ctl, CTL_STALL); end
    step();
    EX_MemR = 1'b0;  // bubble now in EX
    #1;
    n_cmp++;
    if (a_ctl !== CTL_NORM) begin n_bad++; $display("FAIL lu_after: got %b required %b", a_ctl, CTL_NORM); end
    n_cmp++;
    if (a_stall !== 32'd1) begin n_bad++; $display("FAIL lu_cnt: got %0d required 1", a_stall); end
    $display("test_load_use done");
  endtask

  task automatic test_rt_match();
    do_reset();
    EX_MemR = 1'b1; EX_Rt = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
    #1;
    n_cmp++;
    if (a_ctl !== CTL_NORM) begin n_bad++; $display("FAIL rt_unused: got %b required %b", a_ctl, CTL_NORM); end
    ID_UsesRt = 1'b1;
    #1;
    n_cmp++;
    if (a_ctl !== CTL_STALL) begin n_bad++; $display("FAIL rt_used: got %b required %b", a_ctl, CTL_STALL); end
    EX_Rt = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    #1;
    n_cmp++;
    if (a_ctl !== CTL_NORM) begin n_bad++; $display("FAIL rt_zero: got %b required %b", a_ctl, CTL_NORM); end
    step();
    #1;
    n_cmp++;
    if (a_stall !== 32'd0 || a_ctl !== CTL_NORM) begin
      n_bad++; $display("FAIL rt_zero_cnt: got %0d/%b required 0/%b", a_stall, a_ctl, CTL_NORM);
    end
    $display("test_rt_match done");
  endtask

  task automatic test_branch();
    do_reset();
    BranchTaken = 1'b1;
    #1;
    n_cmp++;
    if (b_ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL br_c1: got %b required %b", b_ctl, CTL_FLUSH); end
    step();
    BranchTaken = 1'b0;
    #1;
    n_cmp++;
    if (b_ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL br_c2: got %b required %b", b_ctl, CTL_FLUSH); end
    n_cmp++;
    if (a_ctl !== CTL_NORM) begin n_bad++; $display("FAIL br_a_c2: got %b required %b", a_ctl, CTL_NORM); end
    step();
    #1;
    n_cmp++;
    if (b_ctl !== CTL_NORM) begin n_bad++; $display("FAIL br_c3: got %b required %b", b_ctl, CTL_NORM); end
    n_cmp++;
    if (b_flush !== 32'd1 || b_stall !== 32'd0) begin
      n_bad++; $display("FAIL br_cnt: got %0d/%0d required 1/0", b_flush, b_stall);
    end
    $display("test_branch done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_load_use();
    BranchTaken = 1'b1;
    #1;
    n_cmp++;
    if (a_ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL sim_ctl: got %b required %b", a_ctl, CTL_FLUSH); end
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (a_stall !== 32'd0 || a_flush !== 32'd1) begin
      n_bad++; $display("FAIL sim_cnt: got %0d/%0d required 0/1", a_stall, a_flush);
    end
    // Jump in the second cycle of a 3-cycle stall on dut_b
    do_reset();
    set_load_use();
    #1;
    n_cmp++;
    if (b_ctl !== CTL_STALL) begin n_bad++; $display("FAIL abort_c1: got %b required %b", b_ctl, CTL_STALL); end
    step();
    EX_MemR = 1'b0;
    Jump = 1'b1;
    #1;
    n_cmp++;
    if (b_ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL abort_c2: got %b required %b", b_ctl, CTL_FLUSH); end
    step();
    Jump = 1'b0;
    #1;
    n_cmp++;
    if (b_ctl !== CTL_FLUSH) begin n_bad++; $display("FAIL abort_c3: got %b required %b", b_ctl, CTL_FLUSH); end
    step();
    #1;
    n_cmp++;
    if (b_ctl !== CTL_NORM) begin n_bad++; $display("FAIL abort_c4: got %b required %b", b_ctl, CTL_NORM); end
    n_cmp++;
    if (b_stall !== 32'd1 || b_flush !== 32'd1) begin
      n_bad++; $display("FAIL abort_cnt: got %0d/%0d required 1/1", b_stall, b_flush);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_stall3();
    do_reset();
    set_load_use();
    step();
    EX_MemR = 1'b0;  // bubble; remaining cycles still stall
    #1;
    n_cmp++;
    if (b_ctl !== CTL_STALL) begin n_bad++; $display("FAIL st3_c2: got %b required %b", b_ctl, CTL_STALL); end
    step();
    #1;
    n_cmp++;
    if (b_ctl !== CTL_STALL) begin n_bad++; $display("FAIL st3_c3: got %b required %b", b_ctl, CTL_STALL); end
    step();
    #1;
    n_cmp++;
    if (b_ctl !== CTL_NORM || b_stall !== 32'd3) begin
      n_bad++; $display("FAIL st3_end: got %b/%0d required %b/3", b_ctl, b_stall, CTL_NORM);
    end
    $display("test_stall3 done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_load_use();
    step();
    EX_MemR = 1'b0;
    Rst = 1'b1;
    #1;
    n_cmp++;
    if (b_ctl !== CTL_RST) begin n_bad++; $display("FAIL rmid_ctl: got %b required %b", b_ctl, CTL_RST); end
    step();
    Rst = 1'b0;
    #1;
    n_cmp++;
    if (b_ctl !== CTL_NORM) begin n_bad++; $display("FAIL rmid_run: got %b required %b", b_ctl, CTL_NORM); end
    n_cmp++;
    if (b_stall !== 32'd0 || b_flush !== 32'd0) begin
      n_bad++; $display("FAIL rmid_cnt: got %0d/%0d required 0/0", b_stall, b_flush);
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_load_use();
    step();
    #1;
    n_cmp++;
    if (a_ctl !== CTL_STALL) begin n_bad++; $display("FAIL b2b_c2: got %b required %b", a_ctl, CTL_STALL); end
    step();
    EX_MemR = 1'b0;
    #1;
    n_cmp++;
    if (a_ctl !== CTL_NORM || a_stall !== 32'd2) begin
      n_bad++; $display("FAIL b2b_end: got %b/%0d required %b/2", a_ctl, a_stall, CTL_NORM);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut_a.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut_a.r_stall_cnt;
    set_load_use();
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if (a_stall !== 32'd0) begin n_bad++; $display("FAIL wrap: got %h required 00000000", a_stall); end
    $display("test_counter_wrap done");
  endtask

  initial begin
    Rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_rt_match();
    test_branch();
    test_simultaneous();
    test_stall3();
    test_reset_mid();
    test_back_to_back();
    test_counter_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller driving the control end of the ID/EX interface. It detects load-use hazards and EX-stage redirects (taken branch or jump), then generates four controls: the `Nop` bubble into the ID/EX register, PC and IF/ID write-enables, and the IF/ID flush. It also keeps stall and flush performance counters. It sits beside the ID/EX register, reading that register's outputs and the decode-stage register selects.

## Interface
Parameters:
- `LOAD_STALL`, 1: bubble cycles inserted per load-use hazard (≥1).
- `FLUSH_CYCLES`, 1: cycles IF/ID and ID/EX are flushed per redirect (≥1).

Ports:
- `Clk`  in  1  clock; all state updates on posedge.
- `Rst`  in  1  synchronous, active-high reset.
- `ID_Rs`  in  5  rs of instruction in ID (opCode[25:21]).
- `ID_Rt`  in  5  rt of instruction in ID (opCode[20:16]).
- `ID_UsesRt`  in  1  instruction in ID reads rt (R-type, store, branch).
- `EX_MemR`  in  1  MemR_ID from ID/EX; instruction in EX is a load.
- `EX_Rt`  in  5  EX_rfReSel2; load destination register.
- `BranchTaken`  in  1  branch resolved taken in EX.
- `Jump`  in  1  jump_ID from ID/EX.
- `Nop`  out  1  to ID/EX: zero MemW/RegW of the entering instruction.
- `PCWrite`  out  1  PC update enable.
- `IFIDWrite`  out  1  IF/ID load enable.
- `IFIDFlush`  out  1  IF/ID clear to bubble.
- `StallCnt`  out  32  load-use stall cycles since reset.
- `FlushCnt`  out  32  redirect events since reset.

## Operation
- `Redirect = BranchTaken | Jump`.
- `LoadUse = EX_MemR & (EX_Rt != 0) & ((EX_Rt == ID_Rs) | (ID_UsesRt & EX_Rt == ID_Rt))`.
- FSM states:
  - RUN: no hazard.
  - STALL: holds the remaining load bubbles.
  - FLUSH: holds the remaining flush cycles.
- 8-bit down-counter `cnt` holds the remaining cycles.
- RUN:
  - Redirect: outputs Nop=1, IFIDFlush=1, PCWrite=1, IFIDWrite=1.
    - If FLUSH_CYCLES>1: go to FLUSH, cnt=FLUSH_CYCLES-2.
  - Else LoadUse: outputs Nop=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
    - If LOAD_STALL>1: go to STALL, cnt=LOAD_STALL-2.
  - Else: Nop=0, PCWrite=1, IFIDWrite=1, IFIDFlush=0.
- STALL: outputs as the LoadUse case; cnt==0 → RUN, else cnt-1.
- FLUSH: outputs Nop=1, IFIDFlush=1, PCWrite=1, IFIDWrite=1; cnt==0 → RUN, else cnt-1.
- Priority: Redirect > LoadUse in every state.
  - Redirect in STALL aborts the stall; the FLUSH sequence restarts as if taken from RUN.
  - Redirect in FLUSH reloads cnt.
- StallCnt: +1 every cycle with IFIDWrite=0 and Rst=0.
- FlushCnt: +1 every cycle Redirect=1 and Rst=0.
- Both counters wrap 0xFFFFFFFF→0.

## Timing
- Nop, PCWrite, IFIDWrite and IFIDFlush are combinational from state, cnt and inputs.
  - They are valid in the same cycle as the hazard so the ID/EX register samples them at the next edge.
  - Zero-cycle latency.
- A load-use hazard costs exactly LOAD_STALL cycles.
- A redirect costs exactly FLUSH_CYCLES cycles.
- While Rst=1: Nop=1, IFIDFlush=1, PCWrite=0, IFIDWrite=0.
- After the first edge with Rst=1: state=RUN, cnt=0, StallCnt=0, FlushCnt=0.
- Rst asserted mid-STALL/FLUSH abandons the sequence.
- First cycle after Rst deasserts: RUN outputs, evaluated against the current inputs.
- Hazard re-evaluation on leaving STALL: uses the current inputs. If the ID/EX holds a bubble then, LoadUse is 0.
- EX_Rt==0 never stalls.

## Structure
- Shared package holds:
  - state encoding constants `HZ_RUN`/`HZ_STALL`/`HZ_FLUSH` (2 bits);
  - the `REG_ZERO` 5'd0 constant;
  - a 32-bit counter width constant.
- One natural sub-module: `lu_detect`, the combinational load-use comparator (ID_Rs, ID_Rt, ID_UsesRt, EX_MemR, EX_Rt → LoadUse), reusable by a future MEM-stage load check.

## Test plan
- Load-use, defaults: EX_MemR=1, EX_Rt=8, ID_Rs=8 → one cycle Nop=1/PCWrite=0/IFIDWrite=0; next cycle with a bubble in EX → all normal; StallCnt=1.
- Rt-only match: EX_Rt=9, ID_Rt=9, ID_UsesRt=0 → no stall; ID_UsesRt=1 → stall. EX_Rt=0=ID_Rs → never stall.
- Branch redirect, FLUSH_CYCLES=2: BranchTaken pulse → Nop=1 and IFIDFlush=1 for 2 cycles, PCWrite=1 throughout; FlushCnt=1.
- Simultaneous events: Redirect and LoadUse in the same cycle → flush outputs only, StallCnt unchanged. With LOAD_STALL=3, a Jump in the 2nd stall cycle → stall aborted, flush taken.
- Reset mid-operation: Rst during STALL (LOAD_STALL=3) → Nop=1, PCWrite=0 while Rst=1; afterwards state RUN and both counters 0.
- Counter wrap: force StallCnt to 0xFFFFFFFF, one stall cycle → 0.
